// File: rtl/pbuff_scanout.sv
// pbuff_scanout: VGA read side of the Nios II pixel buffer.
// Generates 640x480@60 timing from a divided pixel enable and scans the
// 160x120 4-bit buffer with 4x4 pixel replication through a registered-read
// port. The pipeline is two clocks deep: stage 1 registers the read address
// and the de/hs/vs copies, and stage 2 registers colour and the VGA outputs.
// frame_start and in_vblank come straight from the counters, unpipelined.
// Build option: define PBUFF_SCANOUT_PALETTE_EN to map each pixel through the
// fixed 16-entry CGA palette. Without it, r=g=b=pixel value (greyscale).
module pbuff_scanout #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int PB_W    = H_VIS / 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  output logic [14:0] pb_rd_adr,
  input  logic [3:0]  pb_rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start,
  output logic        in_vblank
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOT - 1);
  localparam logic [H_W-1:0]   H_VIS_C   = H_W'(H_VIS);
  localparam logic [H_W-1:0]   HS_BEG    = H_W'(H_VIS + H_FP);
  localparam logic [H_W-1:0]   HS_END    = H_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0]   V_VIS_C   = V_W'(V_VIS);
  localparam logic [V_W-1:0]   V_LASTVIS = V_W'(V_VIS - 1);
  localparam logic [V_W-1:0]   VS_BEG    = V_W'(V_VIS + V_FP);
  localparam logic [V_W-1:0]   VS_END    = V_W'(V_VIS + V_FP + V_SYNC);

  // Row-major buffer address of screen pixel (h,v) under 4x4 replication.
  function automatic logic [14:0] pb_addr(input logic [H_W-1:0] h,
                                          input logic [V_W-1:0] v);
    logic [14:0] row;
    logic [14:0] col;
    row = 15'(v >> 2);
    col = 15'(h >> 2);
    return row * 15'(PB_W) + col;
  endfunction

  // Pixel index to 12-bit {r,g,b}.
  function automatic logic [11:0] pix_to_rgb(input logic [3:0] pix);
    logic [11:0] rgb;
`ifdef PBUFF_SCANOUT_PALETTE_EN
    case (pix)
      4'h0:    rgb = 12'h000;
      4'h1:    rgb = 12'h00A;
      4'h2:    rgb = 12'h0A0;
      4'h3:    rgb = 12'h0AA;
      4'h4:    rgb = 12'hA00;
      4'h5:    rgb = 12'hA0A;
      4'h6:    rgb = 12'hA50;
      4'h7:    rgb = 12'hAAA;
      4'h8:    rgb = 12'h555;
      4'h9:    rgb = 12'h55F;
      4'hA:    rgb = 12'h5F5;
      4'hB:    rgb = 12'h5FF;
      4'hC:    rgb = 12'hF55;
      4'hD:    rgb = 12'hF5F;
      4'hE:    rgb = 12'hFF5;
      default: rgb = 12'hFFF;
    endcase
`else
    rgb = {pix, pix, pix};
`endif
    return rgb;
  endfunction

  logic [DIV_W-1:0] pix_div;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             pix_en;
  logic             h_wrap;

  assign pix_en = (pix_div == DIV_LAST);
  assign h_wrap = pix_en && (h_cnt == H_LAST);

  // Pixel clock divider: pix_en fires on the last clk of each pixel period.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)  pix_div <= '0;
    else if (pix_en)     pix_div <= '0;
    else                 pix_div <= pix_div + 1'b1;
  end

  // Raster counters: h advances per pixel, v advances on each h wrap.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  logic        vis_c;
  logic        hs_c;
  logic        vs_c;
  logic [14:0] adr_c;

  assign vis_c = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_c  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_c  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign adr_c = vis_c ? pb_addr(h_cnt, v_cnt) : 15'd0;

  // ---- stage 1: buffer read address and timing copies ----
  logic de_p1;
  logic hs_p1;
  logic vs_p1;

  // Issue the read address and register de/hs/vs alongside it.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pb_rd_adr <= 15'd0;
      de_p1     <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
    end else begin
      pb_rd_adr <= adr_c;
      de_p1     <= vis_c;
      hs_p1     <= hs_c;
      vs_p1     <= vs_c;
    end
  end

  // ---- stage 2: colour and VGA outputs ----
  // pb_rd_data answers the address issued one clk earlier. Each buffer pixel
  // is held for 4*CLK_DIV clks, so the colour trails de/hs/vs by one clk only
  // on the first clk of each 4-pixel block.
  logic [11:0] rgb_c;
  assign rgb_c = pix_to_rgb(pb_rd_data);

  // Register the colour, blanked outside the visible region, plus aligned syncs.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_de                <= 1'b0;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= de_p1 ? rgb_c : 12'h000;
      vga_de                <= de_p1;
      vga_hs                <= hs_p1;
      vga_vs                <= vs_p1;
    end
  end

  // Vertical-blank status for software, taken straight from the counters.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      frame_start <= 1'b0;
      in_vblank   <= 1'b0;
    end else begin
      frame_start <= h_wrap && (v_cnt == V_LASTVIS);
      in_vblank   <= (v_cnt >= V_VIS_C);
    end
  end

endmodule

// File: tb/tb_pbuff_scanout.sv
// Bench for pbuff_scanout: a full-size instance (640x480 timing) covers reset,
// line timing and addressing near the top of the frame. A shrunken instance
// covers whole frames, vertical timing and randomly placed resets, with
// random buffer contents. Expected values come from the cycle count since
// the last reset, converted to raster position with plain arithmetic.
module tb_pbuff_scanout;

  localparam int B_CD = 2, B_HV = 640, B_HFP = 16, B_HS = 96, B_HBP = 48;
  localparam int B_VV = 480, B_VFP = 10, B_VS = 2, B_VBP = 33, B_PBW = 160;
  localparam int S_CD = 3, S_HV = 16, S_HFP = 2, S_HS = 4, S_HBP = 2;
  localparam int S_VV = 12, S_VFP = 1, S_VS = 2, S_VBP = 2, S_PBW = 4;

  localparam int S_HTOT  = S_HV + S_HFP + S_HS + S_HBP;
  localparam int S_VTOT  = S_VV + S_VFP + S_VS + S_VBP;
  localparam int S_FRAME = S_CD * S_HTOT * S_VTOT;
  localparam int S_VBCLK = S_CD * S_HTOT * (S_VTOT - S_VV);
  localparam int S_VSCLK = S_CD * S_HTOT * S_VS;

`ifdef PBUFF_SCANOUT_PALETTE_EN
  localparam logic [11:0] PAL6 = 12'hA50;
`else
  localparam logic [11:0] PAL6 = 12'h666;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] adr_b, adr_s;
  logic [3:0]  rd_b, rd_s;
  logic [3:0]  r_b, g_b, b_b, r_s, g_s, b_s;
  logic        hs_b, vs_b, de_b, fs_b, vb_b;
  logic        hs_s, vs_s, de_s, fs_s, vb_s;
  logic [3:0]  mem_s [256];

  int n_chk = 0;
  int n_err = 0;
  int m = 0;
  bit phase1 = 1'b0;
  int hs_low = 0;
  bit fs_valid = 1'b0;
  int fs_last = 0;
  int vb_run = 0;
  int vs_run = 0;
  int fs_seen = 0;

  always #5 clk = ~clk;

  pbuff_scanout u_big (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .pb_rd_adr(adr_b), .pb_rd_data(rd_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b),
    .frame_start(fs_b), .in_vblank(vb_b)
  );

  pbuff_scanout #(
    .CLK_DIV(S_CD), .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .PB_W(S_PBW)
  ) u_small (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .pb_rd_adr(adr_s), .pb_rd_data(rd_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s),
    .frame_start(fs_s), .in_vblank(vb_s)
  );

  // External dual-port RAM read ports, one clk registered-read latency.
  always @(posedge clk) begin
    rd_b <= adr_b[3:0];
    rd_s <= mem_s[adr_s[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at m=%0d: got %0h expected %0h", tag, m, got, exp);
    end
  endtask

  function automatic int cd(input bit sm);   return sm ? S_CD : B_CD; endfunction
  function automatic int hv(input bit sm);   return sm ? S_HV : B_HV; endfunction
  function automatic int vv(input bit sm);   return sm ? S_VV : B_VV; endfunction
  function automatic int pbw(input bit sm);  return sm ? S_PBW : B_PBW; endfunction
  function automatic int hsb(input bit sm);  return sm ? S_HV + S_HFP : B_HV + B_HFP; endfunction
  function automatic int hse(input bit sm);  return hsb(sm) + (sm ? S_HS : B_HS); endfunction
  function automatic int vsb(input bit sm);  return sm ? S_VV + S_VFP : B_VV + B_VFP; endfunction
  function automatic int vse(input bit sm);  return vsb(sm) + (sm ? S_VS : B_VS); endfunction
  function automatic int htot(input bit sm);
    return sm ? S_HTOT : B_HV + B_HFP + B_HS + B_HBP;
  endfunction
  function automatic int vtot(input bit sm);
    return sm ? S_VTOT : B_VV + B_VFP + B_VS + B_VBP;
  endfunction

  // Raster position k clocks after reset.
  function automatic void pos(input bit sm, input int k, output int h, output int v);
    int p;
    p = k / cd(sm);
    h = p % htot(sm);
    v = (p / htot(sm)) % vtot(sm);
  endfunction

  // Expected pb_rd_adr in the state s clocks after reset.
  function automatic logic [14:0] adr_exp(input bit sm, input int s);
    int h, v;
    if (s < 1) return 15'd0;
    pos(sm, s - 1, h, v);
    if (h >= hv(sm) || v >= vv(sm)) return 15'd0;
    return 15'((v / 4) * pbw(sm) + h / 4);
  endfunction

  function automatic logic [3:0] ram_val(input bit sm, input logic [14:0] a);
    return sm ? mem_s[a[7:0]] : a[3:0];
  endfunction

  function automatic bit fs_exp(input bit sm, input int k);
    int h, v;
    pos(sm, k, h, v);
    return (k % cd(sm) == 0) && (h == 0) && (v == vv(sm));
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [3:0] pix);
`ifdef PBUFF_SCANOUT_PALETTE_EN
    case (pix)
      4'h0: return 12'h000;  4'h1: return 12'h00A;
      4'h2: return 12'h0A0;  4'h3: return 12'h0AA;
      4'h4: return 12'hA00;  4'h5: return 12'hA0A;
      4'h6: return 12'hA50;  4'h7: return 12'hAAA;
      4'h8: return 12'h555;  4'h9: return 12'h55F;
      4'hA: return 12'h5F5;  4'hB: return 12'h5FF;
      4'hC: return 12'hF55;  4'hD: return 12'hF5F;
      4'hE: return 12'hFF5;  default: return 12'hFFF;
    endcase
`else
    return {pix, pix, pix};
`endif
  endfunction

  task automatic check_inst(input bit sm, input logic [14:0] adr, input logic [11:0] rgb,
                            input logic hs, input logic vs, input logic de,
                            input logic fs, input logic vb);
    int h, v;
    logic e_de, e_hs, e_vs, e_vb;
    logic [3:0] pix;
    logic [11:0] e_rgb;
    string p;
    p = sm ? "s_" : "b_";
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_rgb = 12'h000; pix = 4'h0;
    if (m >= 2) begin
      pos(sm, m - 2, h, v);
      e_de = (h < hv(sm)) && (v < vv(sm));
      e_hs = !((h >= hsb(sm)) && (h < hse(sm)));
      e_vs = !((v >= vsb(sm)) && (v < vse(sm)));
      pix  = ram_val(sm, adr_exp(sm, m - 2));
      if (e_de) e_rgb = exp_rgb(pix);
    end
    if (m >= 1) begin
      pos(sm, m - 1, h, v);
      e_vb = (v >= vv(sm));
    end
    chk({p, "adr"}, 32'(adr), 32'(adr_exp(sm, m)));
    chk({p, "rgb"}, 32'(rgb), 32'(e_rgb));
    chk({p, "de"},  32'(de),  32'(e_de));
    chk({p, "hs"},  32'(hs),  32'(e_hs));
    chk({p, "vs"},  32'(vs),  32'(e_vs));
    chk({p, "frame_start"}, 32'(fs), 32'(fs_exp(sm, m)));
    chk({p, "in_vblank"},   32'(vb), 32'(e_vb));
    if (e_de && pix == 4'h6) chk({p, "pal6"}, 32'(rgb), 32'(PAL6));
  endtask

  task automatic check_all();
    check_inst(1'b0, adr_b, {r_b, g_b, b_b}, hs_b, vs_b, de_b, fs_b, vb_b);
    check_inst(1'b1, adr_s, {r_s, g_s, b_s}, hs_s, vs_s, de_s, fs_s, vb_s);
    if (phase1) begin
      if (m == 1)    chk("b_de_before_rise", 32'(de_b), 32'd0);
      if (m == 2)    chk("b_de_rise", 32'(de_b), 32'd1);
      if (m == 1313) chk("b_hs_before_fall", 32'(hs_b), 32'd1);
      if (m == 1314) chk("b_hs_fall", 32'(hs_b), 32'd0);
      if (m == 1401) chk("b_adr_hblank", 32'(adr_b), 32'd0);
      if (m == 6409) chk("b_adr_4_4", 32'(adr_b), 32'd161);
      if (m >= 2000 && m < 3600) hs_low += int'(!hs_b);
      if (m == 3600) chk("b_hs_low_per_line", 32'(hs_low), 32'd192);
      fs_seen += int'(fs_s);
    end
    if (fs_s) begin
      if (fs_valid) begin
        chk("s_frame_period", 32'(m - fs_last), 32'(S_FRAME));
        chk("s_vblank_clks", 32'(vb_run), 32'(S_VBCLK));
        chk("s_vsync_low_clks", 32'(vs_run), 32'(S_VSCLK));
      end
      fs_valid = 1'b1;
      fs_last  = m;
      vb_run   = 0;
      vs_run   = 0;
    end
    vb_run += int'(vb_s);
    vs_run += int'(!vs_s);
  endtask

  // One clock: track clocks since reset at the edge, check at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      m = 0;
      fs_valid = 1'b0;
    end else begin
      m++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem_s[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int exp_fs;
    rst_n = 1'b0;
    fill_mem();
    repeat (5) cycle();
    rst_n  = 1'b1;
    phase1 = 1'b1;
    repeat (12900) cycle();
    phase1 = 1'b0;
    exp_fs = 0;
    for (int k = 1; k <= m; k++) exp_fs += int'(fs_exp(1'b1, k));
    chk("s_frame_start_count", 32'(fs_seen), 32'(exp_fs));
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(200, 3000)) cycle();
      rst_n = 1'b0;
      fill_mem();
      repeat ($urandom_range(1, 3)) cycle();
      rst_n = 1'b1;
    end
    repeat (3000) cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
